// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arithmetic/compare ops plus iterative
// shift-add MUL and restoring DIVU, with registered result and flags.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, alu_ill, is_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_iter = 1'b0;
        case (control)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_MUL, OP_DIVU: is_iter = 1'b1;
            default: alu_ill = 1'b1;
        endcase
    end

    // MUL keeps {hi, multiplier} and shifts right; DIVU keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (res_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, res_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = control;
                    cnt_d = '0;
                    hi_d  = '0;
                    if (is_iter) begin
                        state_d = S_BUSY;
                        res_d   = (control == OP_MUL) ? b : a;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        ill_d   = alu_ill;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    hi_d  = mul_sum[WIDTH:1];
                    res_d = {mul_sum[0], res_q[WIDTH-1:1]};
                end else begin
                    hi_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    res_d = {res_q[WIDTH-2:0], div_ge};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    zero_d  = (res_d == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    res_d   = '0;
                    hi_d    = '0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule
